// File: rtl/calf_traffic_gen_pkg.sv
// Shared definitions for the CALF traffic generator: mode encodings,
// control-word field placement, and the LFSR used for rate and destination draws.
package calf_traffic_gen_pkg;

    // Injection modes selected by the mode input.
    typedef enum logic [1:0] {
        MODE_UNIFORM = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_HOTSPOT = 2'd2,
        MODE_IDLE    = 2'd3
    } tg_mode_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Control word layout, MSB to LSB: {valid, dest, src, seq}.
    localparam int CTRL_SEQ = 0;

    // Total control-word width.
    function automatic int ctrl_w(input int dest_w, input int seq_w);
        return 1 + 2 * dest_w + seq_w;
    endfunction

    // Bit offset of the source-id field.
    function automatic int ctrl_src(input int seq_w);
        return seq_w;
    endfunction

    // Bit offset of the destination-id field.
    function automatic int ctrl_dest(input int dest_w, input int seq_w);
        return seq_w + dest_w;
    endfunction

    // Bit position of the valid flag.
    function automatic int ctrl_valid(input int dest_w, input int seq_w);
        return seq_w + 2 * dest_w;
    endfunction

    // One step of the 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/calf_tg_fifo.sv
// Small first-word-fall-through FIFO holding pending injection flits.
// The head is presented combinationally; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module calf_tg_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are only visible through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/calf_traffic_gen.sv
// Per-node traffic generator and ejection checker for the CALF bufferless
// router. Rate-controlled flits are queued and offered to one router port;
// ejected flits are counted, destination-checked and latency-accounted.
module calf_traffic_gen
    import calf_traffic_gen_pkg::*;
#(
    parameter int          NNODES   = 16,
    parameter int          DEST_W   = 4,
    parameter int          MY_ID    = 0,
    parameter int          SEQ_W    = 8,
    parameter int          TS_W     = 16,
    parameter int          DATA_W   = 32,
    parameter int          QDEPTH   = 4,
    parameter int          MAX_PKTS = 1024,
    parameter int          HOTSPOT  = 0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [7:0]                   rate,
    input  logic [DEST_W-1:0]            fixed_dest,
    input  logic                         inj_ready,
    output logic                         inj_valid,
    output logic [1+2*DEST_W+SEQ_W-1:0]  inj_ctrl,
    output logic [DATA_W-1:0]            inj_data,
    input  logic [1+2*DEST_W+SEQ_W-1:0]  ej_ctrl,
    input  logic [DATA_W-1:0]            ej_data,
    output logic [31:0]                  sent_count,
    output logic [31:0]                  recv_count,
    output logic [15:0]                  err_count,
    output logic [15:0]                  drop_count,
    output logic [39:0]                  lat_sum,
    output logic [TS_W-1:0]              lat_max,
    output logic                         done
);
    localparam int CW        = ctrl_w(DEST_W, SEQ_W);
    localparam int FW        = CW + TS_W;
    localparam int V_BIT     = ctrl_valid(DEST_W, SEQ_W);
    localparam int DEST_LSB  = ctrl_dest(DEST_W, SEQ_W);
    localparam int GEN_W     = $clog2(MAX_PKTS + 1);
    localparam int NEXT_ID_I = (MY_ID + 1) % NNODES;

    localparam logic [15:0]       SEED_EFF  = seed_fix(SEED);
    localparam logic [DEST_W:0]   NN_W      = NNODES[DEST_W:0];
    localparam logic [DEST_W-1:0] MY_ID_W   = MY_ID[DEST_W-1:0];
    localparam logic [DEST_W-1:0] NEXT_ID_W = NEXT_ID_I[DEST_W-1:0];
    localparam logic [DEST_W-1:0] HOT_W     = HOTSPOT[DEST_W-1:0];
    localparam logic [GEN_W-1:0]  MAX_W     = MAX_PKTS[GEN_W-1:0];

    // Control inputs are sampled once so generation decisions use stable values.
    logic              en_q;
    tg_mode_e          mode_q;
    logic [7:0]        rate_q;
    logic [DEST_W-1:0] fdest_q;

    logic [TS_W-1:0]   cyc_q, cyc_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [31:0]       sent_q, sent_d;
    logic [31:0]       recv_q, recv_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       drop_q, drop_d;
    logic [39:0]       lat_sum_q, lat_sum_d;
    logic [TS_W-1:0]   lat_max_q, lat_max_d;
    logic              done_q, done_d;

    logic [DEST_W:0]   uni_ext;
    logic [DEST_W-1:0] uni_dest;
    logic [DEST_W-1:0] gen_dest;
    logic              gen_attempt, push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_wr, fifo_rd;

    logic              ej_valid;
    logic [DEST_W-1:0] ej_dest;
    logic [TS_W-1:0]   lat;
    logic [40:0]       lat_sum_ext;
    logic              unused_ej;

    // Destination choice: uniform draw folded into range and steered off this node,
    // optionally overridden by the fixed destination or the hotspot.
    always_comb begin
        uni_ext = {1'b0, lfsr_q[8 +: DEST_W]};
        if (uni_ext >= NN_W) begin
            uni_ext = uni_ext - NN_W;
        end
        uni_dest = uni_ext[DEST_W-1:0];
        if (uni_dest == MY_ID_W) begin
            uni_dest = NEXT_ID_W;
        end
        case (mode_q)
            MODE_FIXED:   gen_dest = fdest_q;
            MODE_HOTSPOT: gen_dest = (lfsr_q[11:8] == 4'd0) ? HOT_W : uni_dest;
            default:      gen_dest = uni_dest;
        endcase
    end

    assign gen_attempt = en_q && (mode_q != MODE_IDLE) && (gen_q < MAX_W) &&
                         (lfsr_q[7:0] < rate_q);
    assign pop         = !fifo_empty && inj_ready;
    assign push        = gen_attempt && (!fifo_full || pop);
    assign drop        = gen_attempt && fifo_full && !pop;
    assign fifo_wr     = {1'b1, gen_dest, MY_ID_W, seq_q, cyc_q};

    calf_tg_fifo #(
        .WIDTH (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (fifo_wr),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Injection port shows the queue head, forced to zero while empty.
    assign inj_valid = !fifo_empty;
    assign inj_ctrl  = fifo_empty ? '0 : fifo_rd[FW-1:TS_W];

    generate
        if (DATA_W > TS_W) begin : g_pad
            assign inj_data = fifo_empty ? '0 : {{(DATA_W - TS_W){1'b0}}, fifo_rd[TS_W-1:0]};
        end else begin : g_nopad
            assign inj_data = fifo_empty ? '0 : fifo_rd[TS_W-1:0];
        end
    endgenerate

    // Ejection decode; latency is modular so a wrapped counter still measures correctly.
    assign ej_valid    = ej_ctrl[V_BIT];
    assign ej_dest     = ej_ctrl[DEST_LSB +: DEST_W];
    assign lat         = cyc_q - ej_data[TS_W-1:0];
    assign lat_sum_ext = {1'b0, lat_sum_q} + 41'(lat);
    assign unused_ej   = ^{ej_ctrl, ej_data};

    // Next-state for free-running state, generation bookkeeping and saturating counters.
    always_comb begin
        cyc_d     = cyc_q + TS_W'(1);
        lfsr_d    = lfsr_next(lfsr_q);
        seq_d     = seq_q;
        gen_d     = gen_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        err_d     = err_q;
        drop_d    = drop_q;
        lat_sum_d = lat_sum_q;
        lat_max_d = lat_max_q;
        done_d    = done_q | ((gen_q == MAX_W) && fifo_empty);
        if (push) begin
            seq_d = seq_q + SEQ_W'(1);
            gen_d = gen_q + GEN_W'(1);
        end
        if (pop && !(&sent_q)) begin
            sent_d = sent_q + 32'd1;
        end
        if (drop && !(&drop_q)) begin
            drop_d = drop_q + 16'd1;
        end
        if (ej_valid) begin
            if (!(&recv_q)) begin
                recv_d = recv_q + 32'd1;
            end
            if ((ej_dest != MY_ID_W) && !(&err_q)) begin
                err_d = err_q + 16'd1;
            end
            lat_sum_d = lat_sum_ext[40] ? '1 : lat_sum_ext[39:0];
            if (lat > lat_max_q) begin
                lat_max_d = lat;
            end
        end
    end

    // State registers; reset clears everything and reloads the LFSR seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_UNIFORM;
            rate_q    <= '0;
            fdest_q   <= '0;
            cyc_q     <= '0;
            lfsr_q    <= SEED_EFF;
            seq_q     <= '0;
            gen_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            err_q     <= '0;
            drop_q    <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
            done_q    <= 1'b0;
        end else begin
            en_q      <= enable;
            mode_q    <= tg_mode_e'(mode);
            rate_q    <= rate;
            fdest_q   <= fixed_dest;
            cyc_q     <= cyc_d;
            lfsr_q    <= lfsr_d;
            seq_q     <= seq_d;
            gen_q     <= gen_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            lat_sum_q <= lat_sum_d;
            lat_max_q <= lat_max_d;
            done_q    <= done_d;
        end
    end

    assign sent_count = sent_q;
    assign recv_count = recv_q;
    assign err_count  = err_q;
    assign drop_count = drop_q;
    assign lat_sum    = lat_sum_q;
    assign lat_max    = lat_max_q;
    assign done       = done_q;

endmodule

// File: tb/tb_calf_traffic_gen.sv
// Scoreboard bench for calf_traffic_gen: a cycle model predicts every queued
// flit, and flits accepted on the injection port are compared in order.
module tb_calf_traffic_gen;
    localparam int NN   = 16;
    localparam int DW   = 4;
    localparam int ID   = 5;
    localparam int SW   = 8;
    localparam int TW   = 16;
    localparam int DAW  = 32;
    localparam int QD   = 4;
    localparam int MAXP = 8;
    localparam int HOT  = 9;
    localparam int CWB  = 1 + 2 * DW + SW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [1:0]     mode;
    logic [7:0]     rate;
    logic [DW-1:0]  fixed_dest;
    logic           inj_ready;
    logic           inj_valid;
    logic [CWB-1:0] inj_ctrl;
    logic [DAW-1:0] inj_data;
    logic [CWB-1:0] ej_ctrl;
    logic [DAW-1:0] ej_data;
    logic [31:0]    sent_count;
    logic [31:0]    recv_count;
    logic [15:0]    err_count;
    logic [15:0]    drop_count;
    logic [39:0]    lat_sum;
    logic [TW-1:0]  lat_max;
    logic           done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calf_traffic_gen #(
        .NNODES(NN), .DEST_W(DW), .MY_ID(ID), .SEQ_W(SW), .TS_W(TW),
        .DATA_W(DAW), .QDEPTH(QD), .MAX_PKTS(MAXP), .HOTSPOT(HOT), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .rate(rate),
        .fixed_dest(fixed_dest), .inj_ready(inj_ready), .inj_valid(inj_valid),
        .inj_ctrl(inj_ctrl), .inj_data(inj_data), .ej_ctrl(ej_ctrl), .ej_data(ej_data),
        .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count),
        .drop_count(drop_count), .lat_sum(lat_sum), .lat_max(lat_max), .done(done)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr, m_cyc, m_drop;
    logic        m_en;
    logic [1:0]  m_mode;
    logic [7:0]  m_rate, m_seq;
    logic [3:0]  m_fdest, m_dest;
    int          m_gen, m_cnt;
    logic        m_attempt, m_pop, m_push, m_drp;
    logic [32:0] exp_q[$];   // {ctrl[16:0], ts[15:0]}

    function automatic logic [3:0] pick_dest(input logic [15:0] l, input logic [1:0] md,
                                             input logic [3:0] fd);
        int d;
        if (md == 2'd1) return fd;
        if (md == 2'd2 && l[11:8] == 4'd0) return 4'(HOT);
        d = int'(l[11:8]);
        if (d >= NN) d = d - NN;
        if (d == ID) d = (ID + 1) % NN;
        return 4'(d);
    endfunction

    always_comb begin
        m_attempt = m_en && (m_mode != 2'd3) && (m_gen < MAXP) && (m_lfsr[7:0] < m_rate);
        m_pop     = (m_cnt != 0) && inj_ready;
        m_push    = m_attempt && ((m_cnt < QD) || m_pop);
        m_drp     = m_attempt && (m_cnt == QD) && !m_pop;
        m_dest    = pick_dest(m_lfsr, m_mode, m_fdest);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr  <= SEED;
            m_cyc   <= 16'd0;
            m_en    <= 1'b0;
            m_mode  <= 2'd0;
            m_rate  <= 8'd0;
            m_fdest <= 4'd0;
            m_seq   <= 8'd0;
            m_gen   <= 0;
            m_cnt   <= 0;
            m_drop  <= 16'd0;
            exp_q.delete();
        end else begin
            m_lfsr  <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_cyc   <= m_cyc + 16'd1;
            m_en    <= enable;
            m_mode  <= mode;
            m_rate  <= rate;
            m_fdest <= fixed_dest;
            if (m_push) begin
                exp_q.push_back({1'b1, m_dest, 4'(ID), m_seq, m_cyc});
                m_seq <= m_seq + 8'd1;
                m_gen <= m_gen + 1;
            end
            m_cnt <= m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_drp && m_drop != 16'hFFFF) m_drop <= m_drop + 16'd1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'd1; rate = 8'd0; fixed_dest = 4'd0;
        inj_ready = 1'b0; ej_ctrl = '0; ej_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance one cycle; report whether the head will be accepted at the next edge
    // and the scoreboard entry it should match.
    task automatic step(input logic rdy, output bit popped, output logic [CWB-1:0] oc,
                        output logic [DAW-1:0] od, output logic [32:0] ex, output bit have);
        @(negedge clk);
        inj_ready = rdy;
        #1;
        popped = (inj_valid === 1'b1) && rdy;
        oc = inj_ctrl;
        od = inj_data;
        have = 1'b0;
        ex = '0;
        if (popped && exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            have = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'd0; rate = 8'd0; fixed_dest = 4'd0;
        inj_ready = 1'b0; ej_ctrl = '0; ej_data = '0;
        @(negedge clk);
        checks++;
        if ({inj_valid, inj_ctrl, inj_data, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b ctrl=%h data=%h done=%b want all 0",
                     inj_valid, inj_ctrl, inj_data, done);
        end
        checks++;
        if ({sent_count, recv_count, err_count, drop_count, lat_sum, lat_max} !== '0) begin
            errors++;
            $display("FAIL reset_counters got sent=%0d recv=%0d err=%0d drop=%0d sum=%0d max=%0d want 0",
                     sent_count, recv_count, err_count, drop_count, lat_sum, lat_max);
        end
    endtask

    task automatic test_steady_stream();
        bit popped, have;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        logic [7:0] nseq;
        nseq = 8'd0;
        do_reset();
        mode = 2'd1; fixed_dest = 4'd3; rate = 8'd255; inj_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step(1'b1, popped, oc, od, ex, have);
            if (c == 1) begin
                checks++;
                if (inj_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL steady_first_cycle got valid=%b want 0", inj_valid);
                end
            end
            checks++;
            if (inj_valid !== (m_cnt != 0)) begin
                errors++;
                $display("FAIL steady_valid cycle %0d got %b want %b", c, inj_valid, (m_cnt != 0));
            end
            if (popped) begin
                checks++;
                if (!have || oc !== {1'b1, 4'd3, 4'(ID), nseq} || od !== {16'h0, ex[15:0]}) begin
                    errors++;
                    $display("FAIL steady_flit got ctrl=%h data=%h want ctrl=%h data=%h",
                             oc, od, {1'b1, 4'd3, 4'(ID), nseq}, {16'h0, ex[15:0]});
                end else begin
                    $display("TX steady seq=%0d dest=%0d ts=%0d", nseq, oc[15:12], od[15:0]);
                end
                nseq = nseq + 8'd1;
            end
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL steady_drops got %0d want 0", drop_count);
        end
    endtask

    task automatic test_backpressure();
        bit popped, have;
        logic [CWB-1:0] oc, head;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        logic [7:0] nseq;
        bit head_set;
        nseq = 8'd0; head_set = 1'b0; head = '0;
        do_reset();
        mode = 2'd1; fixed_dest = 4'd3; rate = 8'd255; enable = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step(1'b0, popped, oc, od, ex, have);
            if (inj_valid === 1'b1 && !head_set) begin
                head = inj_ctrl; head_set = 1'b1;
            end else if (head_set) begin
                checks++;
                if (inj_ctrl !== head || inj_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_head_held got valid=%b ctrl=%h want 1/%h", inj_valid, inj_ctrl, head);
                end
            end
            checks++;
            if (drop_count !== m_drop) begin
                errors++;
                $display("FAIL bp_drop_count got %0d want %0d", drop_count, m_drop);
            end
        end
        checks++;
        if (drop_count === 16'd0 || m_cnt != QD) begin
            errors++;
            $display("FAIL bp_queue_full got drops=%0d occupancy=%0d want drops>0 occupancy=%0d",
                     drop_count, m_cnt, QD);
        end
        for (int c = 0; c < 30; c++) begin
            step(1'b1, popped, oc, od, ex, have);
            if (popped) begin
                checks++;
                if (!have || oc[7:0] !== nseq || {oc, od[15:0]} !== ex) begin
                    errors++;
                    $display("FAIL bp_order got ctrl=%h ts=%h want seq=%0d entry=%h", oc, od[15:0], nseq, ex);
                end else begin
                    $display("TX backpressure seq=%0d ts=%0d", nseq, od[15:0]);
                end
                nseq = nseq + 8'd1;
            end
        end
        checks++;
        if (nseq !== 8'(MAXP) || sent_count !== 32'(MAXP)) begin
            errors++;
            $display("FAIL bp_total got popped=%0d sent=%0d want %0d", nseq, sent_count, MAXP);
        end
    endtask

    task automatic test_ejection();
        bit popped, have;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        do_reset();
        for (int i = 0; i < 300 && m_cyc != 16'd110; i++) step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = {1'b1, 4'(ID), 4'd2, 8'd7}; ej_data = 32'd100;
        step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = '0; ej_data = '0;
        step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = {1'b1, 4'(ID + 1), 4'd2, 8'd8}; ej_data = 32'd105;
        step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = '0; ej_data = '0;
        step(1'b0, popped, oc, od, ex, have);
        $display("EJ recv=%0d err=%0d lat_sum=%0d lat_max=%0d", recv_count, err_count, lat_sum, lat_max);
        checks++;
        if (recv_count !== 32'd2 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL ej_counts got recv=%0d err=%0d want 2/1", recv_count, err_count);
        end
        checks++;
        if (lat_sum !== 40'd17 || lat_max !== 16'd10) begin
            errors++;
            $display("FAIL ej_latency got sum=%0d max=%0d want 17/10", lat_sum, lat_max);
        end
    endtask

    task automatic test_ts_wrap();
        bit popped, have;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        do_reset();
        for (int i = 0; i < 20 && m_cyc != 16'd3; i++) step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = {1'b1, 4'(ID), 4'd1, 8'd0}; ej_data = 32'h0000_FFFE;
        step(1'b0, popped, oc, od, ex, have);
        ej_ctrl = '0; ej_data = '0;
        step(1'b0, popped, oc, od, ex, have);
        $display("EJ wrap lat_sum=%0d lat_max=%0d", lat_sum, lat_max);
        checks++;
        if (lat_sum !== 40'd5 || lat_max !== 16'd5 || recv_count !== 32'd1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL ts_wrap got sum=%0d max=%0d recv=%0d err=%0d want 5/5/1/0",
                     lat_sum, lat_max, recv_count, err_count);
        end
    endtask

    task automatic test_modes();
        bit popped, have;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        int npop;
        for (int md = 0; md <= 2; md += 2) begin
            npop = 0;
            do_reset();
            mode = 2'(md); rate = 8'd128; enable = 1'b1; fixed_dest = 4'd0;
            for (int c = 0; c < 80; c++) begin
                step(1'b1, popped, oc, od, ex, have);
                if (popped) begin
                    npop++;
                    checks++;
                    if (!have || {oc, od} !== {ex[32:16], 16'h0, ex[15:0]}) begin
                        errors++;
                        $display("FAIL mode%0d_flit got ctrl=%h data=%h want entry=%h", md, oc, od, ex);
                    end else begin
                        $display("TX mode%0d seq=%0d dest=%0d", md, oc[7:0], oc[15:12]);
                    end
                    if (md == 0) begin
                        checks++;
                        if (oc[15:12] === 4'(ID)) begin
                            errors++;
                            $display("FAIL mode0_self_dest got dest=%0d want != %0d", oc[15:12], ID);
                        end
                    end
                end
            end
            checks++;
            if (npop != MAXP || sent_count !== 32'(MAXP)) begin
                errors++;
                $display("FAIL mode%0d_total got popped=%0d sent=%0d want %0d", md, npop, sent_count, MAXP);
            end
        end
    endtask

    task automatic test_completion();
        bit popped, have;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        int npop, pop_at;
        npop = 0; pop_at = -1;
        do_reset();
        mode = 2'd1; fixed_dest = 4'd7; rate = 8'd255; enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step((i % 2) == 0, popped, oc, od, ex, have);
            if (popped) begin
                npop++;
                checks++;
                if (!have || {oc, od[15:0]} !== ex) begin
                    errors++;
                    $display("FAIL done_flit got ctrl=%h ts=%h want %h", oc, od[15:0], ex);
                end
                if (npop == MAXP) pop_at = i;
            end
            if (pop_at < 0 || i <= pop_at + 1) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early cycle %0d got done=%b want 0", i, done);
                end
            end
            if (pop_at >= 0 && i == pop_at + 1) begin
                checks++;
                if (sent_count !== 32'd8) begin
                    errors++;
                    $display("FAIL done_sent got %0d want 8", sent_count);
                end
            end
            if (pop_at >= 0 && i == pop_at + 2) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_rise got done=%b want 1", done);
                end
                break;
            end
        end
        checks++;
        if (pop_at < 0) begin
            errors++;
            $display("FAIL done_timeout got %0d pops want %0d", npop, MAXP);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, popped, oc, od, ex, have);
            checks++;
            if (inj_valid !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold got valid=%b done=%b want 0/1", inj_valid, done);
            end
        end
        $display("DONE sent=%0d done=%b", sent_count, done);
    endtask

    task automatic test_reset_midrun();
        bit popped, have, got_first;
        logic [CWB-1:0] oc;
        logic [DAW-1:0] od;
        logic [32:0] ex;
        got_first = 1'b0;
        do_reset();
        mode = 2'd1; fixed_dest = 4'd2; rate = 8'd255; enable = 1'b1;
        ej_ctrl = {1'b1, 4'(ID), 4'd0, 8'd0}; ej_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, popped, oc, od, ex, have);
            ej_ctrl = '0;
        end
        for (int i = 0; i < 20 && m_cnt != 3; i++) step(1'b0, popped, oc, od, ex, have);
        checks++;
        if (inj_valid !== 1'b1 || sent_count === 32'd0 || recv_count === 32'd0) begin
            errors++;
            $display("FAIL midrun_setup got valid=%b sent=%0d recv=%0d want 1/>0/>0",
                     inj_valid, sent_count, recv_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({inj_valid, inj_ctrl, inj_data, done} !== '0 ||
            {sent_count, recv_count, err_count, drop_count, lat_sum, lat_max} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got valid=%b sent=%0d recv=%0d drop=%0d done=%b want all 0",
                     inj_valid, sent_count, recv_count, drop_count, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20 && !got_first; i++) begin
            step(1'b1, popped, oc, od, ex, have);
            if (popped) begin
                got_first = 1'b1;
                checks++;
                if (!have || oc[7:0] !== 8'd0 || {oc, od[15:0]} !== ex) begin
                    errors++;
                    $display("FAIL midrun_first_seq got ctrl=%h want seq 0 entry=%h", oc, ex);
                end else begin
                    $display("TX after-reset seq=%0d", oc[7:0]);
                end
            end
        end
        checks++;
        if (!got_first) begin
            errors++;
            $display("FAIL midrun_timeout got no flit want one");
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; rate = 8'd0; fixed_dest = 4'd0;
        inj_ready = 1'b0; ej_ctrl = '0; ej_data = '0;
        test_reset();
        test_steady_stream();
        test_backpressure();
        test_ejection();
        test_ts_wrap();
        test_modes();
        test_completion();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
